imm_ext_pipe: RTL
=================

Name: imm_ext_pipe

Overview:
- Parametrised, registered immediate-extension stage for the datapath.
- Accepts an IN_W-bit immediate and a 2-bit mode over a valid/ready handshake.
- Produces an OUT_W-bit zero-, sign- or upper-extended value after one clock.
- 2-entry skid buffer gives full throughput with a registered in_ready, so the stage can be placed between decode and execute when moving from single-cycle to pipelined operation.

Parameters:
- IN_W, 16: immediate input width; legal range is 2 or more.
- OUT_W, 32: extended output width; must be greater than IN_W (OUT_W=30 is the word-address configuration).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  producer presents in_imm/in_mode
- in_ready  output  1  stage can accept; registered
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  00 zero-ext, 01 sign-ext, 10 upper, 11 reserved (see Optional Feature)
- out_valid  output  1  out_imm/out_err hold a result
- out_ready  input  1  consumer accepts
- out_imm  output  OUT_W  extended immediate
- out_err  output  1  result came from an illegal mode

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n). All state changes occur on the rising edge.
- Extension function, computed combinationally at input, E = ext(in_imm, in_mode):
  - 00: upper OUT_W-IN_W bits are 0, low bits are in_imm.
  - 01: upper bits replicate in_imm[IN_W-1].
  - 10: if OUT_W >= 2*IN_W, in_imm is placed at bits [OUT_W-1 : OUT_W-IN_W] with zeros below. Otherwise in_imm is shifted left by OUT_W-IN_W and truncated to OUT_W.
  - 11 (feature off): E=0, err=1. Modes 00, 01 and 10 always give err=0.
- Storage: main register M (drives the outputs) and skid register S, each holding {E, err}.
- State machine (count):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: M valid, out_valid=1, in_ready=1.
  - FULL: M and S valid, out_valid=1, in_ready=0.
- Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY: on accept, load M and go to ONE.
- ONE:
  - accept & pop: load M, stay in ONE.
  - accept only: load S, go to FULL.
  - pop only: go to EMPTY.
  - neither: hold.
- FULL: on pop, move S to M and go to ONE. in_valid is ignored because in_ready=0.
- in_ready is a register: 1 in EMPTY and ONE, 0 in FULL. It is never a combinational function of out_ready.
- Latency: an accepted item is visible on out_* on the following cycle.
- Throughput: one item per clock while out_ready=1.
- Ordering is strict FIFO. No item is dropped or duplicated.
- out_imm and out_err hold stable while out_valid=1 and out_ready=0.
- In EMPTY, out_imm and out_err hold their last value; the consumer must ignore them.
- Reset (including mid-transfer, any state): next edge gives EMPTY, out_valid=0, in_ready=1, out_imm=0, out_err=0. Contents of S are discarded.
- Inputs sampled while in_ready=0 have no effect.

Optional Feature:
- Macro: IMM_EXT_BRANCH_SHIFT_EN.
- Defined: mode 11 becomes branch-offset mode. E = (sign-extended in_imm) << 2, truncated to OUT_W, with err=0. out_err is then tied to 0.
- Undefined: mode 11 is reserved and behaves as specified above (E=0, err=1).
- Handshake and state behaviour are identical in both builds.

Test Plan:
- IN_W=16, OUT_W=32, out_ready=1; send modes 00/01/10 with imm 0x8001 -> next cycle out_imm = 0x00008001 / 0xFFFF8001 / 0x80010000, out_err=0.
- OUT_W=30; mode 01 with 0xFFFF -> 0x3FFFFFFF; mode 01 with 0x7FFF -> 0x00007FFF.
- out_ready=0, send 3 back-to-back items A,B,C -> A and B accepted, in_ready=0 from the cycle after B. Release out_ready -> outputs A, B, C in order, no loss.
- Continuous in_valid=1 and out_ready=1 for 8 items -> 8 results on 8 consecutive cycles; in_ready stays 1.
- Reach FULL, assert rst_n=0 for one cycle -> out_valid=0, in_ready=1, out_imm=0; the next item emerges with no stale data.
- Mode 11 with imm 0xFFFE -> feature off: out_imm=0, out_err=1; IMM_EXT_BRANCH_SHIFT_EN defined: out_imm=0xFFFFFFF8, out_err=0.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer (valid/ready both sides).
// Optional build macro IMM_EXT_BRANCH_SHIFT_EN turns mode 11 into a branch-offset (sext << 2) mode.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_err
);

  localparam int PAD_W = OUT_W - IN_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic             err;
  } res_t;

  logic [1:0] state_q, state_d;
  logic       in_ready_q, in_ready_d;
  res_t       m_q, m_d;
  res_t       s_q, s_d;
  res_t       ext_res;
  logic       accept, pop;

  // Upper mode is always in_imm << PAD_W; since OUT_W > IN_W nothing of in_imm is ever lost.
  always_comb begin
    ext_res = '0;
    case (in_mode)
      2'b00:   ext_res.imm = {{PAD_W{1'b0}}, in_imm};
      2'b01:   ext_res.imm = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
      2'b10:   ext_res.imm = {in_imm, {PAD_W{1'b0}}};
      default: begin
`ifdef IMM_EXT_BRANCH_SHIFT_EN
        ext_res.imm = {{PAD_W{in_imm[IN_W-1]}}, in_imm} << 2;
`else
        ext_res.err = 1'b1;
`endif
      end
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          m_d     = ext_res;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          m_d = ext_res;
        end else if (accept) begin
          s_d     = ext_res;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready: depends only on next occupancy, never on out_ready combinationally.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_imm   = m_q.imm;
  // With the branch-shift build every mode yields err=0, so this is constant 0 there.
  assign out_err   = m_q.err;

endmodule
